// File: rtl/dmem_initiator_if.sv
// Command, response and data-memory port signals of the dmem initiator.
// master is the initiator's view; slave is the command source / memory side.
interface dmem_initiator_if #(
  parameter int XLEN = 64
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [XLEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_data;
  logic [7:0]      cmd_mask;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  logic            load_a_valid;
  logic            load_a_ready;
  logic [XLEN-1:0] load_a_addr;
  logic            load_d_valid;
  logic [XLEN-1:0] load_d_data;

  logic            wvalid;
  logic            wready;
  logic [XLEN-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic [7:0]      wmask;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output load_a_valid, load_a_addr,
    input  load_a_ready, load_d_valid, load_d_data,
    output wvalid, waddr, wdata, wmask,
    input  wready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  load_a_valid, load_a_addr,
    output load_a_ready, load_d_valid, load_d_data,
    input  wvalid, waddr, wdata, wmask,
    output wready
  );
endinterface

// File: rtl/dmem_initiator.sv
// Turns write/read/check commands into dmem port accesses, one outstanding; write 2 cycles, read 4 + memory latency.
// Every request/response is held stable until its ready; cmd_ready is only high in IDLE.
module dmem_initiator #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  dmem_initiator_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] mismatch_cnt
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WREQ  = 3'd1;
  localparam logic [2:0] S_RREQ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RSP   = 3'd4;

  localparam int          NB       = (XLEN / 8 < 8) ? XLEN / 8 : 8;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]       state;
  logic             init_q;
  logic             is_check;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  data_q;
  logic [7:0]       mask_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic             rsp_err_q;
  logic [15:0]      tmo_cnt;
  logic             miscmp;
  logic [CNT_W-1:0] cnt_inc;

  // Byte-wise compare of returned data against the expected word, masked lanes only.
  always_comb begin
    miscmp = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (mask_q[i] && (bus.load_d_data[8*i +: 8] != data_q[8*i +: 8])) begin
        miscmp = 1'b1;
      end
    end
  end

  assign cnt_inc = (&mismatch_cnt) ? mismatch_cnt : mismatch_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      init_q       <= 1'b0;
      is_check     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      tmo_cnt      <= '0;
      mismatch_cnt <= '0;
    end else begin
      // init_q keeps cmd_ready low for every cycle that reset is held
      init_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && init_q) begin
            addr_q   <= bus.cmd_addr;
            data_q   <= bus.cmd_data;
            mask_q   <= bus.cmd_mask;
            is_check <= (bus.cmd_op == 2'd2);
            state    <= (bus.cmd_op == 2'd0) ? S_WREQ : S_RREQ;
          end
        end
        S_WREQ: begin
          if (bus.wready) state <= S_IDLE;
        end
        S_RREQ: begin
          if (bus.load_a_ready) begin
            tmo_cnt <= '0;
            state   <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.load_d_valid) begin
            rsp_data_q <= bus.load_d_data;
            rsp_err_q  <= is_check && miscmp;
            if (is_check && miscmp) mismatch_cnt <= cnt_inc;
            state      <= S_RSP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            mismatch_cnt <= cnt_inc;
            state        <= S_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            rsp_err_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state == S_IDLE) && init_q;
  assign bus.wvalid       = (state == S_WREQ);
  assign bus.waddr        = addr_q;
  assign bus.wdata        = data_q;
  assign bus.wmask        = mask_q;
  assign bus.load_a_valid = (state == S_RREQ);
  assign bus.load_a_addr  = addr_q;
  assign bus.rsp_valid    = (state == S_RSP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign busy             = (state != S_IDLE);
endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: directed timing, vector table, corner sequences and a randomized run
// against a byte-level memory model; the memory responder lives inside tick().
module tb_dmem_initiator;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;

  logic             clk;
  logic             rstn;
  logic             busy;
  logic [CNT_W-1:0] mismatch_cnt;

  dmem_initiator_if #(.XLEN(XLEN)) bus ();

  dmem_initiator #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .busy         (busy),
    .mismatch_cnt (mismatch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [9];

  int checks = 0, errors = 0;
  int rdy_pct = 100, rsp_pct = 100, lat_min = 1, lat_max = 1;
  int stall_w = 0, stall_a = 0, stall_r = 0;
  bit drop_data = 0, d_late = 0;
  int d_cnt = 0;
  logic [63:0] d_addr;
  logic [63:0] mem     [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  bit c_hs, w_hs, a_hs, r_hs, rv_prev;
  logic [63:0] hs_waddr, hs_wdata, hs_aaddr, hs_rdata;
  logic [7:0]  hs_wmask;
  logic        hs_rerr;
  logic [CNT_W-1:0] hs_cnt;
  int cyc = 0, a_cyc = 0, rise_cyc = 0, n_rise = 0;
  int n_w_hs = 0, n_a_hs = 0, n_r_hs = 0, n_wvld = 0, n_avld = 0, n_rvld = 0;
  int n_wr_cmd = 0, n_rd_cmd = 0, n_rsp_cmd = 0;
  bit pw_st = 0, pa_st = 0, pr_st = 0;
  logic [63:0] pw_addr, pw_data, pa_addr, pr_data;
  logic [7:0]  pw_mask;
  logic        pr_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  // One clock: sample at negedge (values seen by the coming edge), then act as memory at edge+1.
  task automatic tick();
    @(negedge clk);
    if (pw_st) begin
      chk("w_hold_vld", bus.wvalid, 1);
      chk("w_hold_addr", bus.waddr, pw_addr);
      chk("w_hold_data", bus.wdata, pw_data);
      chk("w_hold_mask", bus.wmask, pw_mask);
    end
    if (pa_st) begin
      chk("a_hold_vld", bus.load_a_valid, 1);
      chk("a_hold_addr", bus.load_a_addr, pa_addr);
    end
    if (pr_st) begin
      chk("r_hold_vld", bus.rsp_valid, 1);
      chk("r_hold_data", bus.rsp_data, pr_data);
      chk("r_hold_err", bus.rsp_err, pr_err);
    end
    if (bus.wvalid || bus.load_a_valid) chk("w_a_exclusive", bus.wvalid && bus.load_a_valid, 0);
    c_hs  = rstn && bus.cmd_valid && bus.cmd_ready;
    w_hs  = rstn && bus.wvalid && bus.wready;
    a_hs  = rstn && bus.load_a_valid && bus.load_a_ready;
    r_hs  = rstn && bus.rsp_valid && bus.rsp_ready;
    pw_st = rstn && bus.wvalid && !bus.wready;
    pa_st = rstn && bus.load_a_valid && !bus.load_a_ready;
    pr_st = rstn && bus.rsp_valid && !bus.rsp_ready;
    pw_addr = bus.waddr; pw_data = bus.wdata; pw_mask = bus.wmask;
    pa_addr = bus.load_a_addr; pr_data = bus.rsp_data; pr_err = bus.rsp_err;
    if (bus.wvalid) n_wvld++;
    if (bus.load_a_valid) n_avld++;
    if (bus.rsp_valid) n_rvld++;
    if (w_hs) begin hs_waddr = bus.waddr; hs_wdata = bus.wdata; hs_wmask = bus.wmask; n_w_hs++; end
    if (a_hs) begin hs_aaddr = bus.load_a_addr; n_a_hs++; end
    if (r_hs) begin hs_rdata = bus.rsp_data; hs_rerr = bus.rsp_err; hs_cnt = mismatch_cnt; n_r_hs++; end
    @(posedge clk);
    #1;
    cyc++;
    if (!rstn) d_cnt = 0;
    if (w_hs) mem[hs_waddr] = merge(mem_rd(hs_waddr), hs_wdata, hs_wmask);
    if (a_hs) begin
      a_cyc = cyc;
      if (!drop_data) begin d_cnt = int'($urandom_range(lat_max, lat_min)); d_addr = hs_aaddr; end
    end
    bus.load_d_valid = 1'b0;
    bus.load_d_data  = {$urandom, $urandom};
    if (d_late) begin
      bus.load_d_valid = 1'b1;
      d_late = 0;
    end else if (d_cnt > 0) begin
      d_cnt--;
      if (d_cnt == 0) begin bus.load_d_valid = 1'b1; bus.load_d_data = mem_rd(d_addr); end
    end
    if (stall_w > 0) begin bus.wready = 1'b0; if (bus.wvalid) stall_w--; end
    else bus.wready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (stall_a > 0) begin bus.load_a_ready = 1'b0; if (bus.load_a_valid) stall_a--; end
    else bus.load_a_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (stall_r > 0) begin bus.rsp_ready = 1'b0; if (bus.rsp_valid) stall_r--; end
    else bus.rsp_ready = (int'($urandom_range(99, 0)) < rsp_pct);
    if (bus.rsp_valid && !rv_prev) begin rise_cyc = cyc; n_rise++; end
    rv_prev = bus.rsp_valid;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                         input logic [7:0] mask, input logic [63:0] exp_d, input logic exp_e,
                         input int exp_cnt, input string nm);
    int n, w0, r0;
    w0 = n_w_hs; r0 = n_r_hs;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data; bus.cmd_mask = mask;
    n = 0;
    do begin tick(); n++; end while (!c_hs && n < 100);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = {$urandom, $urandom}; bus.cmd_data = {$urandom, $urandom}; bus.cmd_mask = 8'($urandom);
    chk({nm, "_accept"}, c_hs, 1);
    if (op == 2'd0) begin
      n_wr_cmd++;
      n = 0;
      while (n_w_hs == w0 && n < 100) begin tick(); n++; end
      chk({nm, "_waddr"}, hs_waddr, addr);
      chk({nm, "_wdata"}, hs_wdata, data);
      chk({nm, "_wmask"}, hs_wmask, mask);
    end else begin
      n_rd_cmd++; n_rsp_cmd++;
      n = 0;
      while (n_r_hs == r0 && n < 200) begin tick(); n++; end
      chk({nm, "_rsp_seen"}, n_r_hs - r0, 1);
      chk({nm, "_laddr"}, hs_aaddr, addr);
      chk({nm, "_rdata"}, hs_rdata, exp_d);
      chk({nm, "_rerr"}, hs_rerr, exp_e);
      chk({nm, "_mcnt"}, hs_cnt, exp_cnt);
    end
  endtask

  initial begin
    int n, a0, r0, v0, v1, v2, mcnt;
    tbl[0] = '{2'd0, 64'h80002000, 64'hAAAABBBBCCCCDDDD, 8'hFF, 64'h0, 1'b0, 0};
    tbl[1] = '{2'd2, 64'h80002000, 64'hAAAABBBBCCCC0000, 8'hFC, 64'hAAAABBBBCCCCDDDD, 1'b0, 0};
    tbl[2] = '{2'd2, 64'h80002000, 64'hAAAABBBBCCCC0000, 8'h01, 64'hAAAABBBBCCCCDDDD, 1'b1, 1};
    tbl[3] = '{2'd2, 64'h80002000, 64'h0, 8'h00, 64'hAAAABBBBCCCCDDDD, 1'b0, 1};
    tbl[4] = '{2'd0, 64'h80001000, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0, 1'b0, 1};
    tbl[5] = '{2'd1, 64'h80001000, 64'h0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, 1};
    tbl[6] = '{2'd3, 64'h80001000, 64'h0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, 1};
    tbl[7] = '{2'd2, 64'h80001000, 64'h11223344FFFFFFFF, 8'hFF, 64'h11223344FFFFFFFF, 1'b0, 1};
    tbl[8] = '{2'd2, 64'h80002000, 64'h00AABBBBCCCCDDDD, 8'h7F, 64'hAAAABBBBCCCCDDDD, 1'b0, 1};

    rstn = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_addr = 64'h80000000;
    bus.cmd_data = 64'h0; bus.cmd_mask = 8'hFF;
    bus.rsp_ready = 1'b0; bus.load_a_ready = 1'b0; bus.wready = 1'b0;
    bus.load_d_valid = 1'b0; bus.load_d_data = 64'h0;

    // reset held with a pending command
    repeat (3) begin
      tick();
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_valids", {busy, bus.wvalid, bus.load_a_valid, bus.rsp_valid, bus.rsp_err}, 0);
    end
    rstn = 1'b1; bus.cmd_valid = 1'b0;
    tick();
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_mcnt", mismatch_cnt, 0);
    chk("post_rst_rdata", bus.rsp_data, 0);
    chk("post_rst_busy", busy, 0);

    // exact WRITE then READ timing
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_addr = 64'h80001000;
    bus.cmd_data = 64'h1122334455667788; bus.cmd_mask = 8'hFF;
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_N1_wvalid", bus.wvalid, 1);
    chk("wr_N1_cmd_ready", bus.cmd_ready, 0);
    chk("wr_N1_waddr", bus.waddr, 64'h80001000);
    chk("wr_N1_wdata", bus.wdata, 64'h1122334455667788);
    chk("wr_N1_wmask", bus.wmask, 8'hFF);
    tick();
    chk("wr_N2_cmd_ready", bus.cmd_ready, 1);
    chk("wr_N2_wvalid", bus.wvalid, 0);
    n_wr_cmd++;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_addr = 64'h80001000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd_N1_avalid", bus.load_a_valid, 1);
    chk("rd_N1_aaddr", bus.load_a_addr, 64'h80001000);
    tick();
    chk("rd_N2_avalid", bus.load_a_valid, 0);
    chk("rd_N2_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("rd_N3_rsp_valid", bus.rsp_valid, 1);
    chk("rd_N3_rsp_data", bus.rsp_data, 64'h1122334455667788);
    chk("rd_N3_rsp_err", bus.rsp_err, 0);
    chk("rd_latency", rise_cyc - a_cyc, 1);
    tick();
    chk("rd_N4_cmd_ready", bus.cmd_ready, 1);
    chk("rd_N4_rsp_valid", bus.rsp_valid, 0);
    n_rd_cmd++; n_rsp_cmd++;

    rdy_pct = 70; rsp_pct = 70; lat_max = 3;
    for (int i = 0; i < 9; i++)
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].exp_d, tbl[i].exp_e,
              tbl[i].exp_cnt, $sformatf("tbl%0d", i));

    // backpressure on every channel
    rdy_pct = 100; rsp_pct = 100; lat_max = 1;
    stall_w = 5; v0 = n_wvld; a0 = n_w_hs;
    run_cmd(2'd0, 64'h80003000, 64'h0102030405060708, 8'hA5, 64'h0, 1'b0, 1, "bp_wr");
    repeat (3) tick();
    chk("bp_wvalid_cycles", n_wvld - v0, 6);
    chk("bp_one_write", n_w_hs - a0, 1);
    stall_a = 5; stall_r = 4; v1 = n_avld; v2 = n_rvld; a0 = n_a_hs; r0 = n_r_hs;
    run_cmd(2'd1, 64'h80003000, 64'h0, 8'h0, 64'h0100030000060008, 1'b0, 1, "bp_rd");
    repeat (3) tick();
    chk("bp_avalid_cycles", n_avld - v1, 6);
    chk("bp_rvalid_cycles", n_rvld - v2, 5);
    chk("bp_one_load", n_a_hs - a0, 1);
    chk("bp_one_rsp", n_r_hs - r0, 1);

    // timeout, then late data while idle
    drop_data = 1;
    run_cmd(2'd1, 64'h80001000, 64'h0, 8'h0, 64'h0, 1'b1, 2, "tmo");
    chk("tmo_cycles", rise_cyc - a_cyc, TIMEOUT);
    drop_data = 0; d_late = 1; r0 = n_rise;
    repeat (5) tick();
    chk("late_no_rsp", n_rise - r0, 0);
    chk("late_busy", busy, 0);
    chk("late_mcnt", mismatch_cnt, 2);
    run_cmd(2'd1, 64'h80001000, 64'h0, 8'h0, 64'h11223344FFFFFFFF, 1'b0, 2, "after_late");

    // counter saturation
    for (int i = 0; i < 5; i++)
      run_cmd(2'd2, 64'h80002000, 64'h0, 8'hFF, 64'hAAAABBBBCCCCDDDD, 1'b1, 3, $sformatf("sat%0d", i));

    // reset while waiting for load data
    drop_data = 1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_addr = 64'h80001000;
    n = 0;
    do begin tick(); n++; end while (!c_hs && n < 50);
    bus.cmd_valid = 1'b0;
    a0 = n_a_hs; n = 0;
    while (n_a_hs == a0 && n < 50) begin tick(); n++; end
    n_rd_cmd++;
    repeat (3) tick();
    chk("rstrd_busy_before", busy, 1);
    r0 = n_rise;
    rstn = 1'b0;
    tick();
    chk("rstrd_busy", busy, 0);
    chk("rstrd_valids", {bus.cmd_ready, bus.wvalid, bus.load_a_valid, bus.rsp_valid}, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rstrd_cmd_ready", bus.cmd_ready, 1);
    chk("rstrd_mcnt", mismatch_cnt, 0);
    drop_data = 0; d_late = 1;
    repeat (10) tick();
    chk("rstrd_no_rsp", n_rise - r0, 0);
    chk("rstrd_idle", busy, 0);

    // randomized traffic against the byte-level memory model
    rdy_pct = 60; rsp_pct = 60; lat_min = 1; lat_max = 6; mcnt = 0;
    for (int it = 0; it < 150; it++) begin
      logic [1:0]  op;
      logic [63:0] a, d, cur;
      logic [7:0]  m;
      logic        e;
      int          k;
      op  = 2'($urandom_range(3, 0));
      a   = 64'h90000000 + 64'(8 * $urandom_range(7, 0));
      d   = {$urandom, $urandom};
      m   = 8'($urandom);
      cur = ref_rd(a);
      e   = 1'b0;
      if (op == 2'd0) begin
        ref_mem[a] = merge(cur, d, m);
      end else if (op == 2'd2) begin
        if ($urandom_range(3, 0) != 0) begin
          d = cur;
          if ($urandom_range(1, 0) == 1) begin
            k = int'($urandom_range(7, 0));
            d[8*k +: 8] = d[8*k +: 8] ^ 8'($urandom_range(255, 1));
          end
        end
        for (int i = 0; i < 8; i++) if (m[i] && (d[8*i +: 8] != cur[8*i +: 8])) e = 1'b1;
        if (e && mcnt < 3) mcnt++;
      end
      run_cmd(op, a, d, m, cur, e, mcnt, $sformatf("rand%0d", it));
    end
    repeat (10) tick();

    chk("total_writes", n_w_hs, n_wr_cmd);
    chk("total_loads", n_a_hs, n_rd_cmd);
    chk("total_rsps", n_r_hs, n_rsp_cmd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
